// File: rtl/paula_audio_mixer.sv
// Paula audio back end: volume-scaled four-channel mixer with one shared multiplier
// and first-order sigma-delta 1-bit DACs. Optional LFSR dither: PAULA_AUDIO_DITHER_EN.
module paula_audio_mixer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk7_en,
  input  logic [7:0]  sample0,
  input  logic [7:0]  sample1,
  input  logic [7:0]  sample2,
  input  logic [7:0]  sample3,
  input  logic [6:0]  volume0,
  input  logic [6:0]  volume1,
  input  logic [6:0]  volume2,
  input  logic [6:0]  volume3,
  output logic [14:0] left,
  output logic [14:0] right,
  output logic        mix_stb,
  output logic        ldac,
  output logic        rdac
);

  logic [1:0]         phase_r;
  logic [1:0]         phase_nxt_s;
  logic signed [14:0] lacc_r;
  logic signed [14:0] racc_r;
  logic [14:0]        left_r;
  logic [14:0]        right_r;
  logic               mix_stb_r;
  logic [7:0]         mux_sample_s;
  logic [6:0]         mux_volume_s;
  logic signed [13:0] prod_s;
  logic signed [14:0] prod_ext_s;
  logic [15:0]        lsd_acc_r;
  logic [15:0]        rsd_acc_r;
  logic [14:0]        lx_s;
  logic [14:0]        rx_s;
  logic [14:0]        lin_s;
  logic [14:0]        rin_s;

  function automatic logic [6:0] eff_volume(input logic [6:0] vol);
    eff_volume = vol[6] ? 7'd64 : {1'b0, vol[5:0]};
  endfunction

  // Signed 8b sample times unsigned 0..64 volume; result always fits 14b signed.
  function automatic logic signed [13:0] scale(input logic [7:0] smp, input logic [6:0] vol);
    logic signed [15:0] full;
    full  = $signed({{8{smp[7]}}, smp}) * $signed({9'd0, eff_volume(vol)});
    scale = full[13:0];
  endfunction

  // Channel select feeding the single multiplier
  always_comb begin
    mux_sample_s = sample0;
    mux_volume_s = volume0;
    case (phase_r)
      2'd0:    begin mux_sample_s = sample0; mux_volume_s = volume0; end
      2'd1:    begin mux_sample_s = sample1; mux_volume_s = volume1; end
      2'd2:    begin mux_sample_s = sample2; mux_volume_s = volume2; end
      2'd3:    begin mux_sample_s = sample3; mux_volume_s = volume3; end
      default: begin mux_sample_s = sample0; mux_volume_s = volume0; end
    endcase
  end

  assign prod_s     = scale(mux_sample_s, mux_volume_s);
  assign prod_ext_s = {prod_s[13], prod_s};

  // Sequencer next phase: advances only on enabled cycles
  always_comb begin
    if (clk7_en) begin
      phase_nxt_s = phase_r + 2'd1;
    end else begin
      phase_nxt_s = phase_r;
    end
  end

  // Sequencer phase register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_r <= 2'd0;
    end else begin
      phase_r <= phase_nxt_s;
    end
  end

  // Accumulate products and publish the mixed pair on phase 3
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lacc_r    <= 15'sd0;
      racc_r    <= 15'sd0;
      left_r    <= 15'd0;
      right_r   <= 15'd0;
      mix_stb_r <= 1'b0;
    end else begin
      mix_stb_r <= 1'b0;
      if (clk7_en) begin
        case (phase_r)
          2'd0: lacc_r <= prod_ext_s;
          2'd1: racc_r <= prod_ext_s;
          2'd2: racc_r <= racc_r + prod_ext_s;
          2'd3: begin
            left_r    <= lacc_r + prod_ext_s;
            right_r   <= racc_r;
            mix_stb_r <= 1'b1;
          end
          default: mix_stb_r <= 1'b0;
        endcase
      end
    end
  end

  // Offset binary: flipping the sign bit maps -16384..16383 onto 0..32767
  assign lx_s = {~left_r[14], left_r[13:0]};
  assign rx_s = {~right_r[14], right_r[13:0]};

`ifdef PAULA_AUDIO_DITHER_EN
  logic [15:0] lfsr_r;
  logic        lfsr_fb_s;

  function automatic logic [14:0] dither_clamp(input logic [14:0] x, input logic [1:0] d);
    logic signed [16:0] sum;
    sum = $signed({2'b00, x}) + $signed({{15{d[1]}}, d});
    if (sum < 17'sd0) begin
      dither_clamp = 15'd0;
    end else if (sum > 17'sd32767) begin
      dither_clamp = 15'h7FFF;
    end else begin
      dither_clamp = sum[14:0];
    end
  endfunction

  assign lfsr_fb_s = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];

  // Fibonacci LFSR, taps 16,14,13,11, stepping every clk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_r <= 16'hACE1;
    end else begin
      lfsr_r <= {lfsr_r[14:0], lfsr_fb_s};
    end
  end

  assign lin_s = dither_clamp(lx_s, lfsr_r[1:0]);
  assign rin_s = dither_clamp(rx_s, lfsr_r[1:0]);
`else
  assign lin_s = lx_s;
  assign rin_s = rx_s;
`endif

  // Sigma-delta modulators; bit 15 is dropped each step so the carry is the bitstream
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lsd_acc_r <= 16'd0;
      rsd_acc_r <= 16'd0;
    end else begin
      lsd_acc_r <= {1'b0, lsd_acc_r[14:0]} + {1'b0, lin_s};
      rsd_acc_r <= {1'b0, rsd_acc_r[14:0]} + {1'b0, rin_s};
    end
  end

  assign left    = left_r;
  assign right   = right_r;
  assign mix_stb = mix_stb_r;
  assign ldac    = lsd_acc_r[15];
  assign rdac    = rsd_acc_r[15];

endmodule

// File: tb/tb_paula_audio_mixer.sv
// Directed scoreboard bench for paula_audio_mixer (default build, no dither).
module tb_paula_audio_mixer;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk7_en;
  logic [7:0]  sample0, sample1, sample2, sample3;
  logic [6:0]  volume0, volume1, volume2, volume3;
  logic [14:0] left, right;
  logic        mix_stb, ldac, rdac;

  int          errors = 0;
  int          checks = 0;
  logic [29:0] exp_q[$];

  always #5 clk = ~clk;

  paula_audio_mixer dut (
    .clk(clk), .reset(reset), .clk7_en(clk7_en),
    .sample0(sample0), .sample1(sample1), .sample2(sample2), .sample3(sample3),
    .volume0(volume0), .volume1(volume1), .volume2(volume2), .volume3(volume3),
    .left(left), .right(right), .mix_stb(mix_stb), .ldac(ldac), .rdac(rdac)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_inputs(input logic [7:0] s0, input logic [6:0] v0,
                            input logic [7:0] s1, input logic [6:0] v1,
                            input logic [7:0] s2, input logic [6:0] v2,
                            input logic [7:0] s3, input logic [6:0] v3);
    sample0 = s0; volume0 = v0;
    sample1 = s1; volume1 = v1;
    sample2 = s2; volume2 = v2;
    sample3 = s3; volume3 = v3;
  endtask

  task automatic run_pass(input logic [14:0] el, input logic [14:0] er);
    exp_q.push_back({el, er});
    clk7_en = 1'b1;
    repeat (4) tick();
  endtask

  // Monitor: every strobe pops one expected mix and compares it
  always @(negedge clk) begin
    logic [29:0] e;
    if (!reset && mix_stb) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: left=0x%0h right=0x%0h with nothing expected", left, right);
      end else begin
        e = exp_q.pop_front();
        check("mix_left", {17'd0, left}, {17'd0, e[29:15]});
        check("mix_right", {17'd0, right}, {17'd0, e[14:0]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int ones;
    reset   = 1'b1;
    clk7_en = 1'b1;
    set_inputs(8'h00, 7'd0, 8'h00, 7'd0, 8'h00, 7'd0, 8'h00, 7'd0);
    repeat (3) tick();
    check("reset_left", {17'd0, left}, 32'd0);
    check("reset_right", {17'd0, right}, 32'd0);
    check("reset_stb", {31'd0, mix_stb}, 32'd0);
    check("reset_ldac", {31'd0, ldac}, 32'd0);
    check("reset_rdac", {31'd0, rdac}, 32'd0);
    reset = 1'b0;

    // Silence: strobe every 4th clk, DACs alternate 0,1,0,1
    repeat (3) exp_q.push_back(30'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("silence_ldac", {31'd0, ldac}, 32'(i % 2));
      check("silence_rdac", {31'd0, rdac}, 32'(i % 2));
      check("silence_stb", {31'd0, mix_stb}, 32'(i % 4 == 3));
    end

    // Left full scale positive: 255 ones per 256 clocks
    set_inputs(8'h7F, 7'h40, 8'h00, 7'd0, 8'h00, 7'd0, 8'h7F, 7'h40);
    ones = 0;
    fork
      repeat (68) run_pass(15'd16256, 15'd0);
      begin
        repeat (8) @(negedge clk);
        repeat (256) begin
          @(negedge clk);
          ones += int'(ldac);
        end
      end
    join
    check("fullscale_ldac_ones", ones, 32'd255);

    // Right full scale negative, volume 7'h7F clamps to 64: rdac stuck at 0
    set_inputs(8'h00, 7'd0, 8'h80, 7'h7F, 8'h80, 7'h7F, 8'h00, 7'd0);
    ones = 0;
    fork
      repeat (20) run_pass(15'd0, 15'h4000);
      begin
        repeat (8) @(negedge clk);
        repeat (64) begin
          @(negedge clk);
          ones += int'(rdac);
        end
      end
    join
    check("negfull_rdac_ones", ones, 32'd0);

    // -16*10 + 5*3 = -145
    set_inputs(8'hF0, 7'd10, 8'h00, 7'd0, 8'h00, 7'd0, 8'h05, 7'd3);
    run_pass(15'h7F6F, 15'd0);
    run_pass(15'h7F6F, 15'd0);

    // Enable held low mid-pass; late change to sample0 must be ignored
    set_inputs(8'h01, 7'd1, 8'h03, 7'd2, 8'hFF, 7'd1, 8'h02, 7'd1);
    exp_q.push_back({15'd3, 15'd5});
    clk7_en = 1'b1;
    tick();
    sample0 = 8'h7F;
    tick();
    clk7_en = 1'b0;
    ones = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_stb", {31'd0, mix_stb}, 32'd0);
      check("hold_left", {17'd0, left}, 32'h7F6F);
      ones += int'(ldac);
    end
    check("hold_ldac_toggles", {31'd0, (ones > 0 && ones < 20)}, 32'd1);
    clk7_en = 1'b1;
    tick();
    tick();
    sample0 = 8'h01;

    // Reset during phase 2: immediate clear, no partial strobe
    set_inputs(8'hF0, 7'd10, 8'h00, 7'd0, 8'h00, 7'd0, 8'h05, 7'd3);
    tick();
    tick();
    #1;
    reset = 1'b1;
    #1;
    check("midreset_left", {17'd0, left}, 32'd0);
    check("midreset_right", {17'd0, right}, 32'd0);
    check("midreset_stb", {31'd0, mix_stb}, 32'd0);
    check("midreset_ldac", {31'd0, ldac}, 32'd0);
    check("midreset_rdac", {31'd0, rdac}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back({15'h7F6F, 15'd0});
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("post_reset_strobe", {31'd0, mix_stb}, 32'(i == 4));
    end

    tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
